servo_motion_seq: RTL and testbench
===================================

Name: servo_motion_seq

Overview:
- Motion sequencer and protection controller in front of the servo PWM datapath.
- Accepts angle commands through a valid/ready handshake and ramps the setpoint toward the target once per 20 ms servo frame.
- Monitors measured current and angle, then reports settle/done.
- On sustained overcurrent, cuts PWM, cools down, retries, and locks out after repeated faults.

Parameters:
- FRAME_CYCLES, 1000000, clk cycles per servo frame (20 ms at 50 MHz)
- STEP_DEG, 5, maximum setpoint change per frame, in degrees
- I_LIMIT, 40, overcurrent threshold in 0.1 A units; trip condition is strictly greater than
- OC_FRAMES, 2, consecutive over-limit frames needed to trip
- COOLDOWN_FRAMES, 25, frames spent in FAULT before a retry
- MAX_RETRY, 3, faults allowed before LOCKOUT
- SETTLE_FRAMES, 5, consecutive in-tolerance frames needed to declare settled
- TOL_DEG, 2, settle tolerance, |meas - target| <= TOL
- RESET_DEG, 90, setpoint value at reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_grades  in  8  target angle, 0..180
- meas_grades  in  8  measured angle, 0..180
- meas_current  in  8  measured current, 0.1 A units
- fault_clr  in  1  lockout clear pulse
- sp_grades  out  8  setpoint to PWM datapath
- pwm_en  out  1  PWM output enable
- done  out  1  one-cycle pulse when settled
- fault  out  1  high in FAULT
- lockout  out  1  high in LOCKOUT
- state_o  out  3  current state encoding

Interface decision: one clock, clk; reset rst_n, asynchronous, active-low.

Behaviour:
- Reset values:
  - state=IDLE, sp_grades=RESET_DEG, pwm_en=0, done=0, fault=0, lockout=0.
  - All counters 0, target=RESET_DEG.
  - Reset asserted mid-operation forces these values immediately.
- Frame tick:
  - Free-running counter 0..FRAME_CYCLES-1.
  - tick is a one-cycle pulse when the count equals FRAME_CYCLES-1; the first tick occurs FRAME_CYCLES cycles after reset release.
- Handshake:
  - cmd_ready = (state==IDLE or state==HOLD).
  - Accept on cmd_valid & cmd_ready at a clock edge: target <= min(cmd_grades,180), settle_cnt <= 0, state -> RAMP.
  - Accept is registered, so the new target is used from the next cycle.
- Overcurrent check (RAMP and HOLD, on each tick):
  - meas_current > I_LIMIT increments oc_cnt; otherwise oc_cnt <= 0.
  - oc_cnt reaching OC_FRAMES -> FAULT; sp frozen, oc_cnt <= 0, cool_cnt <= 0.
  - The overcurrent check has priority over ramp and settle on the same tick.
- RAMP (on each tick, if no fault):
  - pwm_en=1.
  - If sp != target: sp moves toward target by min(STEP_DEG, |target-sp|); this is unsigned arithmetic with no wrap and sp never overshoots.
  - If sp == target and |meas_grades-target| <= TOL_DEG: settle_cnt++. Otherwise settle_cnt <= 0.
  - settle_cnt reaching SETTLE_FRAMES -> HOLD, done pulses 1 cycle, retry_cnt <= 0.
- HOLD:
  - pwm_en=1, sp held, overcurrent still monitored.
  - A new command restarts RAMP.
- FAULT:
  - pwm_en=0, fault=1; cool_cnt counts ticks.
  - When cool_cnt reaches COOLDOWN_FRAMES: retry_cnt++.
  - If retry_cnt+1 < MAX_RETRY: -> RAMP with sp <= min(meas_grades,180), settle_cnt <= 0.
  - Otherwise -> LOCKOUT.
- LOCKOUT:
  - pwm_en=0, lockout=1.
  - fault_clr=1 -> IDLE, retry_cnt <= 0, sp unchanged.
  - fault_clr in any other state is ignored.
- IDLE: pwm_en=0, sp held.
- Simultaneous events:
  - Command accepted in the same cycle as a fault trip in HOLD: target is updated, state goes to FAULT.
  - cmd_grades > 180 is clamped to 180.
- state_o encoding: IDLE=0, RAMP=1, HOLD=2, FAULT=3, LOCKOUT=4.

Optional Feature:
- SERVO_SEQ_STATS_EN defined:
  - Adds output fault_count (16 bits): total FAULT entries since reset, saturating at 0xFFFF.
  - Adds output settle_time (16 bits): frames from the last accepted command to done, saturating.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Package servo_pkg contains:
  - enum seq_state_t {IDLE,RAMP,HOLD,FAULT,LOCKOUT}
  - typedef deg_t = logic[7:0]
  - typedef cur_t = logic[7:0]
  - constant DEG_MAX=180
- Sub-module servo_frame_timer: parameter FRAME_CYCLES, ports clk, rst_n, tick.

Test Plan (FRAME_CYCLES=100, STEP_DEG=10, I_LIMIT=40, OC_FRAMES=2, COOLDOWN_FRAMES=3, MAX_RETRY=2, SETTLE_FRAMES=3, TOL_DEG=2):
1. Ramp up: cmd 90->130, meas_grades tracks sp, current 10 -> sp goes 100,110,120,130 on 4 successive ticks; done pulses on the 3rd in-tolerance tick after sp=130; state HOLD; cmd_ready=1.
2. Clamp/down-ramp: cmd 200 -> target 180. Then cmd 175 from sp=180 -> sp 175 in one tick, no overshoot.
3. Overcurrent: in HOLD, current=60 for 2 ticks -> FAULT, pwm_en=0 on the 2nd tick. A single-tick spike of 60 followed by 10 -> no trip.
4. Retry/lockout: current stays 60 -> FAULT, 3 ticks later RAMP with sp=meas_grades, 2 ticks later FAULT, 3 ticks later LOCKOUT, lockout=1. fault_clr -> IDLE.
5. Reset mid-RAMP: rst_n low for 3 cycles while sp=110 -> sp=90, state IDLE, pwm_en=0 asynchronously. cmd_valid held high during LOCKOUT -> no accept.

Source files
------------

// File: rtl/servo_pkg.sv
// rtl/servo_pkg.sv - shared state, angle/current types and helpers for the servo sequencer
package servo_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP    = 3'd1,
    HOLD    = 3'd2,
    FAULT   = 3'd3,
    LOCKOUT = 3'd4
  } seq_state_t;

  typedef logic [7:0] deg_t;
  typedef logic [7:0] cur_t;

  localparam deg_t DEG_MAX = 8'd180;

  function automatic deg_t clamp_deg(input deg_t d);
    return (d > DEG_MAX) ? DEG_MAX : d;
  endfunction

  function automatic deg_t abs_diff(input deg_t a, input deg_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// rtl/servo_frame_timer.sv - free-running servo frame counter with one-cycle tick
module servo_frame_timer #(
  parameter int FRAME_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/servo_motion_seq.sv
// rtl/servo_motion_seq.sv - servo motion sequencer: frame-paced ramp, settle detect, overcurrent retry/lockout
// Optional macro SERVO_SEQ_STATS_EN adds the fault_count and settle_time outputs.
module servo_motion_seq
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES    = 1000000,
  parameter int STEP_DEG        = 5,
  parameter int I_LIMIT         = 40,
  parameter int OC_FRAMES       = 2,
  parameter int COOLDOWN_FRAMES = 25,
  parameter int MAX_RETRY       = 3,
  parameter int SETTLE_FRAMES   = 5,
  parameter int TOL_DEG         = 2,
  parameter int RESET_DEG       = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_grades,
  input  logic [7:0] meas_grades,
  input  logic [7:0] meas_current,
  input  logic       fault_clr,
  output logic [7:0] sp_grades,
  output logic       pwm_en,
  output logic       done,
  output logic       fault,
  output logic       lockout,
  output logic [2:0] state_o
`ifdef SERVO_SEQ_STATS_EN
  ,
  output logic [15:0] fault_count,
  output logic [15:0] settle_time
`endif
);

  localparam deg_t       STEP     = deg_t'(STEP_DEG);
  localparam deg_t       TOL      = deg_t'(TOL_DEG);
  localparam deg_t       RST_DEG  = deg_t'(RESET_DEG);
  localparam cur_t       ILIM     = cur_t'(I_LIMIT);
  localparam logic [7:0] OC_N     = 8'(OC_FRAMES);
  localparam logic [7:0] COOL_N   = 8'(COOLDOWN_FRAMES);
  localparam logic [7:0] RETRY_N  = 8'(MAX_RETRY);
  localparam logic [7:0] SETTLE_N = 8'(SETTLE_FRAMES);

  seq_state_t state;
  deg_t       target;
  logic [7:0] oc_cnt, cool_cnt, settle_cnt, retry_cnt;
  logic       tick, accept, over, trip, in_tol, settle_hit;
  deg_t       sp_err, step_mag, ramp_sp;

  servo_frame_timer #(.FRAME_CYCLES(FRAME_CYCLES)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign cmd_ready  = (state == IDLE) || (state == HOLD);
  assign accept     = cmd_valid && cmd_ready;
  assign state_o    = state;
  assign over       = meas_current > ILIM;
  assign trip       = over && ((oc_cnt + 8'd1) >= OC_N);
  assign in_tol     = abs_diff(meas_grades, target) <= TOL;
  // Step magnitude is capped by the remaining error so the setpoint never overshoots.
  assign sp_err     = abs_diff(target, sp_grades);
  assign step_mag   = (sp_err > STEP) ? STEP : sp_err;
  assign ramp_sp    = (target > sp_grades) ? (sp_grades + step_mag) : (sp_grades - step_mag);
  assign settle_hit = tick && (state == RAMP) && !trip && (sp_grades == target) && in_tol &&
                      ((settle_cnt + 8'd1) >= SETTLE_N);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sp_grades  <= RST_DEG;
      target     <= RST_DEG;
      pwm_en     <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      lockout    <= 1'b0;
      oc_cnt     <= '0;
      cool_cnt   <= '0;
      settle_cnt <= '0;
      retry_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        target     <= clamp_deg(cmd_grades);
        settle_cnt <= '0;
        state      <= RAMP;
        pwm_en     <= 1'b1;
      end
      if (state == LOCKOUT && fault_clr) begin
        state     <= IDLE;
        lockout   <= 1'b0;
        retry_cnt <= '0;
      end
      // Trip handling below overrides the state written by a same-cycle accept.
      if (tick) begin
        case (state)
          RAMP, HOLD: begin
            if (trip) begin
              state    <= FAULT;
              pwm_en   <= 1'b0;
              fault    <= 1'b1;
              oc_cnt   <= '0;
              cool_cnt <= '0;
            end else begin
              oc_cnt <= over ? (oc_cnt + 8'd1) : 8'd0;
              if (state == RAMP) begin
                if (sp_grades != target) begin
                  sp_grades  <= ramp_sp;
                  settle_cnt <= '0;
                end else if (in_tol) begin
                  settle_cnt <= settle_cnt + 8'd1;
                  if (settle_hit) begin
                    state     <= HOLD;
                    done      <= 1'b1;
                    retry_cnt <= '0;
                  end
                end else begin
                  settle_cnt <= '0;
                end
              end
            end
          end
          FAULT: begin
            cool_cnt <= cool_cnt + 8'd1;
            if ((cool_cnt + 8'd1) >= COOL_N) begin
              retry_cnt <= retry_cnt + 8'd1;
              fault     <= 1'b0;
              if ((retry_cnt + 8'd1) < RETRY_N) begin
                state      <= RAMP;
                sp_grades  <= clamp_deg(meas_grades);
                settle_cnt <= '0;
                pwm_en     <= 1'b1;
              end else begin
                state   <= LOCKOUT;
                lockout <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SERVO_SEQ_STATS_EN
  logic [15:0] frames_since_cmd;
  logic        fault_entry;

  assign fault_entry = tick && trip && ((state == RAMP) || (state == HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_count      <= '0;
      settle_time      <= '0;
      frames_since_cmd <= '0;
    end else begin
      if (fault_entry && fault_count != 16'hFFFF) begin
        fault_count <= fault_count + 16'd1;
      end
      if (accept) begin
        frames_since_cmd <= '0;
      end else if (tick && frames_since_cmd != 16'hFFFF) begin
        frames_since_cmd <= frames_since_cmd + 16'd1;
      end
      // The settling tick itself is included in the reported frame count.
      if (settle_hit) begin
        settle_time <= (frames_since_cmd == 16'hFFFF) ? 16'hFFFF : (frames_since_cmd + 16'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_servo_motion_seq.sv
// tb/tb_servo_motion_seq.sv - scoreboard bench for servo_motion_seq with a frame-level reference model
module tb_servo_motion_seq;

  localparam int FC    = 100;
  localparam int STEP  = 10;
  localparam int ILIM  = 40;
  localparam int OCF   = 2;
  localparam int COOL  = 3;
  localparam int MR    = 2;
  localparam int SETF  = 3;
  localparam int TOL   = 2;
  localparam int RSTD  = 90;

  localparam int S_IDLE = 0, S_RAMP = 1, S_HOLD = 2, S_FAULT = 3, S_LOCK = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_grades = 8'd0;
  logic [7:0] meas_grades = 8'd90;
  logic [7:0] meas_current = 8'd0;
  logic       fault_clr = 1'b0;
  logic [7:0] sp_grades;
  logic       pwm_en, done, fault, lockout;
  logic [2:0] state_o;
`ifdef SERVO_SEQ_STATS_EN
  logic [15:0] fault_count, settle_time;
`endif

  servo_motion_seq #(
    .FRAME_CYCLES(FC), .STEP_DEG(STEP), .I_LIMIT(ILIM), .OC_FRAMES(OCF),
    .COOLDOWN_FRAMES(COOL), .MAX_RETRY(MR), .SETTLE_FRAMES(SETF),
    .TOL_DEG(TOL), .RESET_DEG(RSTD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_grades(cmd_grades), .meas_grades(meas_grades), .meas_current(meas_current),
    .fault_clr(fault_clr), .sp_grades(sp_grades), .pwm_en(pwm_en), .done(done),
    .fault(fault), .lockout(lockout), .state_o(state_o)
`ifdef SERVO_SEQ_STATS_EN
    , .fault_count(fault_count), .settle_time(settle_time)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int sp;
    int pwm;
    int flt;
    int lck;
    int dn;
    int rdy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   cyc;

  // Reference model: one update per frame plus handshake/clear events.
  int m_state, m_sp, m_target, m_oc, m_cool, m_retry, m_settle, m_done;

  function automatic void chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction

  function automatic void model_reset();
    m_state = S_IDLE; m_sp = RSTD; m_target = RSTD;
    m_oc = 0; m_cool = 0; m_retry = 0; m_settle = 0; m_done = 0;
  endfunction

  function automatic void model_accept(input int deg);
    if (m_state == S_IDLE || m_state == S_HOLD) begin
      m_target = (deg > 180) ? 180 : deg;
      m_settle = 0;
      m_state  = S_RAMP;
    end
  endfunction

  function automatic void model_clr();
    if (m_state == S_LOCK) begin
      m_state = S_IDLE;
      m_retry = 0;
    end
  endfunction

  function automatic void model_tick(input bit cmd, input int deg, input int meas, input int cur);
    int s;
    int d;
    int err;
    s = m_state;
    m_done = 0;
    if (cmd) model_accept(deg);
    if (s == S_RAMP || s == S_HOLD) begin
      m_oc = (cur > ILIM) ? m_oc + 1 : 0;
      if (m_oc == OCF) begin
        m_state = S_FAULT; m_oc = 0; m_cool = 0;
      end else if (s == S_RAMP) begin
        err = (meas > m_target) ? meas - m_target : m_target - meas;
        if (m_sp != m_target) begin
          d = m_target - m_sp;
          if (d > STEP) d = STEP;
          if (d < -STEP) d = -STEP;
          m_sp = m_sp + d;
          m_settle = 0;
        end else if (err <= TOL) begin
          m_settle++;
          if (m_settle == SETF) begin
            m_state = S_HOLD; m_done = 1; m_retry = 0;
          end
        end else begin
          m_settle = 0;
        end
      end
    end else if (s == S_FAULT) begin
      m_cool++;
      if (m_cool == COOL) begin
        m_retry++;
        if (m_retry < MR) begin
          m_state = S_RAMP; m_sp = (meas > 180) ? 180 : meas; m_settle = 0;
        end else begin
          m_state = S_LOCK;
        end
      end
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.st  = m_state;
    e.sp  = m_sp;
    e.pwm = (m_state == S_RAMP || m_state == S_HOLD) ? 1 : 0;
    e.flt = (m_state == S_FAULT) ? 1 : 0;
    e.lck = (m_state == S_LOCK) ? 1 : 0;
    e.dn  = m_done;
    e.rdy = (m_state == S_IDLE || m_state == S_HOLD) ? 1 : 0;
    q.push_back(e);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Monitor: frame edges pop an expected record; other cycles must not pulse done.
  always @(posedge clk) begin
    #1;
    if (rst_n && cyc > 0) begin
      if (cyc % FC == 0) begin
        if (q.size() == 0) begin
          chk($sformatf("f%0d_queue_nonempty", cyc / FC), 0, 1);
        end else begin
          mon_e = q.pop_front();
          chk($sformatf("f%0d_state", cyc / FC), int'(state_o), mon_e.st);
          chk($sformatf("f%0d_sp", cyc / FC), int'(sp_grades), mon_e.sp);
          chk($sformatf("f%0d_pwm_en", cyc / FC), int'(pwm_en), mon_e.pwm);
          chk($sformatf("f%0d_fault", cyc / FC), int'(fault), mon_e.flt);
          chk($sformatf("f%0d_lockout", cyc / FC), int'(lockout), mon_e.lck);
          chk($sformatf("f%0d_done", cyc / FC), int'(done), mon_e.dn);
          chk($sformatf("f%0d_cmd_ready", cyc / FC), int'(cmd_ready), mon_e.rdy);
        end
      end else begin
        chk($sformatf("c%0d_done_offframe", cyc), int'(done), 0);
      end
    end
  end

  // Entered at the negedge before edge 1 of a frame; returns at the same point of the next frame.
  task automatic do_frame(input bit cmd, input int deg, input bit at_tick,
                          input int off, input int cur, input bit clr);
    int meas;
    meas = m_sp + off;
    if (meas < 0) meas = 0;
    if (meas > 185) meas = 185;
    meas_grades  = 8'(meas);
    meas_current = 8'(cur);
    cmd_grades   = 8'(deg);
    for (int e = 1; e <= FC; e++) begin
      cmd_valid = cmd && (at_tick ? (e == FC) : (e == FC / 2));
      fault_clr = clr && (e == 60);
      if (cmd && !at_tick && e == FC / 2) model_accept(deg);
      if (clr && e == 60) model_clr();
      if (e == FC) begin
        model_tick(cmd && at_tick, deg, meas, cur);
        push_expected();
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, int'(state_o), S_IDLE);
    chk({tag, "_sp"}, int'(sp_grades), RSTD);
    chk({tag, "_pwm_en"}, int'(pwm_en), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_lockout"}, int'(lockout), 0);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
  endtask

  task automatic do_reset_mid(input string tag);
    repeat (20) @(negedge clk);
    cmd_valid = 1'b0;
    fault_clr = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_random(input int frames);
    bit c, at, clr;
    int deg, off, cur, r;
    for (int i = 0; i < frames; i++) begin
      c   = ($urandom_range(0, 99) < 30);
      at  = ($urandom_range(0, 99) < 30);
      deg = $urandom_range(0, 220);
      off = ($urandom_range(0, 99) < 60) ? 0 : int'($urandom_range(0, 8)) - 4;
      r   = $urandom_range(0, 99);
      if (r < 20)      cur = $urandom_range(41, 100);
      else if (r < 30) cur = 40;
      else if (r < 35) cur = 41;
      else             cur = $urandom_range(0, 39);
      clr = ($urandom_range(0, 99) < 15);
      do_frame(c, deg, at, off, cur, clr);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Ramp 90 -> 130 and settle into HOLD.
    do_frame(1, 130, 0, 0, 10, 0);
    repeat (7) do_frame(0, 0, 0, 0, 10, 0);
    // Clamp 200 -> 180, then a single-tick down-step to 175.
    do_frame(1, 200, 0, 0, 10, 0);
    repeat (9) do_frame(0, 0, 0, 0, 10, 0);
    do_frame(1, 175, 0, 0, 10, 0);
    repeat (4) do_frame(0, 0, 0, 0, 10, 0);
    // Single overcurrent spike must not trip.
    do_frame(0, 0, 0, 0, 60, 0);
    repeat (2) do_frame(0, 0, 0, 0, 10, 0);
    // Trip coinciding with a command accepted in HOLD, then retry and lockout.
    do_frame(0, 0, 0, 0, 60, 0);
    do_frame(1, 50, 1, 0, 60, 0);
    repeat (8) do_frame(0, 0, 0, 5, 60, 0);
    do_frame(1, 30, 0, 0, 10, 0);
    do_frame(1, 30, 1, 0, 10, 0);
    do_frame(0, 0, 0, 0, 10, 1);
    do_frame(0, 0, 0, 0, 10, 1);
    // Asynchronous reset mid-ramp.
    do_reset_mid("reset_idle");
    do_frame(1, 130, 0, 0, 10, 0);
    do_frame(0, 0, 0, 0, 10, 0);
    do_reset_mid("reset_ramp");

    run_random(250);

    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
